alt_vipcti131_common_control_packet_parser: RTL and testbench

Parametrised successor to the VIP control-packet decoder on the clocked-video-input Avalon-ST path. It passes the stream through with no added latency and parses control packets with a nibble-counting state machine for any SYMBOLS_PER_BEAT from 1 to 4. It commits width, height and interlaced only when a control packet is complete and legal, and flags truncated or illegal packets. It can optionally drop every non-video packet from the output stream.

---
 rtl/alt_vipcti131_common_control_packet_parser.sv | 178 +++++++++++++++++
 tb/tb_alt_vipcti131_common_control_packet_parser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipcti131_common_control_packet_parser.sv
// Avalon-ST video pass-through with control-packet decoding for 1-4 symbols per beat.
// Width, height and interlaced are committed only from complete, legal control packets.

module alt_vipcti131_nib_lane #(
  parameter int K = 0
) (
  input  logic [3:0] nib,
  input  logic [3:0] sym_lo,
  output logic [3:0] idx,
  output logic       vld,
  output logic [3:0] nibble
);
  logic [4:0] sum;

  // symbol K of a payload beat carries nibble number nib+K; only 0..8 are meaningful
  assign sum    = {1'b0, nib} + 5'(K);
  assign vld    = (sum < 5'd9);
  assign idx    = sum[3:0];
  assign nibble = sym_lo;
endmodule

module alt_vipcti131_common_control_packet_parser #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int DEFAULT_WIDTH    = 640,
  parameter int DEFAULT_HEIGHT   = 480,
  parameter int DROP_NON_VIDEO   = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                 width,
  output logic [15:0]                                 height,
  output logic [3:0]                                  interlaced,
  output logic [3:0]                                  packet_type,
  output logic                                        vip_ctrl_valid,
  output logic                                        is_video,
  output logic                                        end_of_video,
  output logic                                        ctrl_error
);
  localparam int S = SYMBOLS_PER_BEAT;

  typedef enum logic [1:0] {IDLE, CTRL, VIDEO, OTHER} state_t;

  state_t           state_q, state_d;
  logic [3:0]       nib_q, nib_d, nib_upd;
  logic [4:0]       nib_sum;
  logic [8:0][3:0]  sh_q, sh_d, sh_upd;
  logic [15:0]      width_d, height_d;
  logic [3:0]       il_d, ptype_d, hdr_type;
  logic             vcv_d, isv_d, err_d;
  logic             acc, pass, commit_ok;
  logic [S-1:0][3:0] lane_idx, lane_nib;
  logic [S-1:0]     lane_vld;
  logic             unused_data;

  assign acc          = din_valid & din_ready;
  assign hdr_type     = din_data[3:0];
  assign din_ready    = dout_ready;
  assign dout_data    = din_data;
  assign dout_sop     = din_sop;
  assign dout_eop     = din_eop;
  assign pass         = (DROP_NON_VIDEO == 0) ? 1'b1 :
                        (din_sop ? (hdr_type == 4'h0) : (state_q == VIDEO));
  assign dout_valid   = acc & pass;
  assign end_of_video = acc & din_eop & is_video;
  assign unused_data  = ^din_data;

  generate
    for (genvar k = 0; k < S; k++) begin : g_lane
      alt_vipcti131_nib_lane #(.K(k)) u_lane (
        .nib    (nib_q),
        .sym_lo (din_data[k*BITS_PER_SYMBOL +: 4]),
        .idx    (lane_idx[k]),
        .vld    (lane_vld[k]),
        .nibble (lane_nib[k])
      );
    end
  endgenerate

  // shadow nibble 0 is width[15:12], nibble 8 is interlaced
  always_comb begin
    sh_upd = sh_q;
    for (int n = 0; n < 9; n++)
      for (int k = 0; k < S; k++)
        if (lane_vld[k] && lane_idx[k] == 4'(n)) sh_upd[n] = lane_nib[k];
  end

  assign nib_sum   = {1'b0, nib_q} + 5'(S);
  assign nib_upd   = (nib_sum > 5'd9) ? 4'd9 : nib_sum[3:0];
  assign commit_ok = (nib_upd == 4'd9) &&
                     ({sh_upd[0], sh_upd[1], sh_upd[2], sh_upd[3]} != 16'd0) &&
                     ({sh_upd[4], sh_upd[5], sh_upd[6], sh_upd[7]} != 16'd0);

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    sh_d     = sh_q;
    width_d  = width;
    height_d = height;
    il_d     = interlaced;
    ptype_d  = packet_type;
    vcv_d    = 1'b0;
    err_d    = 1'b0;
    isv_d    = is_video;
    if (acc) begin
      if (din_sop) begin
        ptype_d = hdr_type;
        nib_d   = '0;
        sh_d    = '0;
        // a new header inside a control packet abandons it
        if (state_q == CTRL) err_d = 1'b1;
        if (hdr_type == 4'hF) begin
          state_d = CTRL;
          if (din_eop) err_d = 1'b1;
        end else if (hdr_type == 4'h0) begin
          state_d = VIDEO;
          vcv_d   = 1'b1;
          isv_d   = 1'b1;
        end else begin
          state_d = OTHER;
          isv_d   = 1'b0;
        end
      end else if (state_q == CTRL) begin
        nib_d = nib_upd;
        sh_d  = sh_upd;
        if (din_eop) begin
          if (commit_ok) begin
            width_d  = {sh_upd[0], sh_upd[1], sh_upd[2], sh_upd[3]};
            height_d = {sh_upd[4], sh_upd[5], sh_upd[6], sh_upd[7]};
            il_d     = sh_upd[8];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      if (din_eop) begin
        state_d = IDLE;
        isv_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      nib_q          <= '0;
      sh_q           <= '0;
      width          <= 16'(DEFAULT_WIDTH);
      height         <= 16'(DEFAULT_HEIGHT);
      interlaced     <= '0;
      packet_type    <= '0;
      vip_ctrl_valid <= 1'b0;
      is_video       <= 1'b0;
      ctrl_error     <= 1'b0;
    end else begin
      state_q        <= state_d;
      nib_q          <= nib_d;
      sh_q           <= sh_d;
      width          <= width_d;
      height         <= height_d;
      interlaced     <= il_d;
      packet_type    <= ptype_d;
      vip_ctrl_valid <= vcv_d;
      is_video       <= isv_d;
      ctrl_error     <= err_d;
    end
  end
endmodule

// File: tb/tb_alt_vipcti131_common_control_packet_parser.sv
// Bench: S=3 pass-all instance (u0) and S=1 drop-non-video instance (u1), checked
// against a packet-level model that collects nibbles in a queue.

module tb_alt_vipcti131_common_control_packet_parser;
  logic clk, rst, dout_ready;
  logic [1:0] vld, sp, ep;
  logic [23:0] d0, dd0;
  logic [7:0]  d1, dd1;
  logic [1:0] o_ready, o_valid, o_sop, o_eop, o_vcv, o_isv, o_eov, o_err;
  logic [1:0][15:0] o_w, o_h;
  logic [1:0][3:0]  o_il, o_pt;

  int errors = 0, checks = 0;
  bit bp = 0;

  int          kind [2];   // 0 none, 1 ctrl, 2 video, 3 other
  logic [15:0] ew [2], eh [2];
  logic [3:0]  eil [2], ept [2];
  bit          evcv [2], eisv [2], eerr [2];
  logic [3:0]  nq [2][$];

  alt_vipcti131_common_control_packet_parser #(
    .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .DEFAULT_WIDTH(640),
    .DEFAULT_HEIGHT(480), .DROP_NON_VIDEO(0)
  ) u0 (
    .clk(clk), .rst(rst), .din_ready(o_ready[0]), .din_valid(vld[0]),
    .din_sop(sp[0]), .din_eop(ep[0]), .din_data(d0), .dout_ready(dout_ready),
    .dout_valid(o_valid[0]), .dout_sop(o_sop[0]), .dout_eop(o_eop[0]),
    .dout_data(dd0), .width(o_w[0]), .height(o_h[0]), .interlaced(o_il[0]),
    .packet_type(o_pt[0]), .vip_ctrl_valid(o_vcv[0]), .is_video(o_isv[0]),
    .end_of_video(o_eov[0]), .ctrl_error(o_err[0])
  );

  alt_vipcti131_common_control_packet_parser #(
    .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .DEFAULT_WIDTH(640),
    .DEFAULT_HEIGHT(480), .DROP_NON_VIDEO(1)
  ) u1 (
    .clk(clk), .rst(rst), .din_ready(o_ready[1]), .din_valid(vld[1]),
    .din_sop(sp[1]), .din_eop(ep[1]), .din_data(d1), .dout_ready(dout_ready),
    .dout_valid(o_valid[1]), .dout_sop(o_sop[1]), .dout_eop(o_eop[1]),
    .dout_data(dd1), .width(o_w[1]), .height(o_h[1]), .interlaced(o_il[1]),
    .packet_type(o_pt[1]), .vip_ctrl_valid(o_vcv[1]), .is_video(o_isv[1]),
    .end_of_video(o_eov[1]), .ctrl_error(o_err[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int sval(input int i); return (i == 0) ? 3 : 1; endfunction
  function automatic bit drop(input int i); return (i == 1); endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      kind[i] = 0; ew[i] = 16'd640; eh[i] = 16'd480; eil[i] = 0; ept[i] = 0;
      evcv[i] = 0; eisv[i] = 0; eerr[i] = 0; nq[i].delete();
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 2; i++) begin evcv[i] = 0; eerr[i] = 0; end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 2; i++) begin
      chk("width", i, o_w[i], ew[i]);
      chk("height", i, o_h[i], eh[i]);
      chk("interlaced", i, o_il[i], eil[i]);
      chk("packet_type", i, o_pt[i], ept[i]);
      chk("vip_ctrl_valid", i, o_vcv[i], evcv[i]);
      chk("is_video", i, o_isv[i], eisv[i]);
      chk("ctrl_error", i, o_err[i], eerr[i]);
    end
  endtask

  task automatic model_accept(input int i, input bit s, input bit e, input logic [23:0] d);
    logic [3:0] ty;
    ty = d[3:0];
    if (s) begin
      ept[i] = ty;
      if (kind[i] == 1) eerr[i] = 1;
      nq[i].delete();
      if (ty == 4'hF) begin kind[i] = 1; if (e) eerr[i] = 1; end
      else if (ty == 4'h0) begin kind[i] = 2; evcv[i] = 1; eisv[i] = 1; end
      else begin kind[i] = 3; eisv[i] = 0; end
    end else if (kind[i] == 1) begin
      for (int k = 0; k < sval(i); k++) nq[i].push_back(d[k*8 +: 4]);
      if (e) begin
        if (nq[i].size() >= 9) begin
          logic [15:0] w, h;
          w = {nq[i][0], nq[i][1], nq[i][2], nq[i][3]};
          h = {nq[i][4], nq[i][5], nq[i][6], nq[i][7]};
          if (w != 0 && h != 0) begin ew[i] = w; eh[i] = h; eil[i] = nq[i][8]; end
          else eerr[i] = 1;
        end else eerr[i] = 1;
      end
    end
    if (e) begin kind[i] = 0; eisv[i] = 0; end
  endtask

  task automatic beat(input int i, input bit s, input bit e, input logic [23:0] d);
    bit done, p;
    done = 0;
    vld[i] = 1; sp[i] = s; ep[i] = e;
    if (i == 0) d0 = d; else d1 = d[7:0];
    while (!done) begin
      dout_ready = bp ? ~dout_ready : 1'b1;
      #1;
      chk("din_ready", i, o_ready[i], dout_ready);
      if (dout_ready) begin
        p = drop(i) ? (s ? (d[3:0] == 4'h0) : (kind[i] == 2)) : 1'b1;
        chk("dout_valid", i, o_valid[i], p);
        chk("end_of_video", i, o_eov[i], e & eisv[i]);
        chk("dout_sop_eop", i, {o_sop[i], o_eop[i]}, {s, e});
        chk("dout_data", i, (i == 0) ? dd0 : 24'(dd1), (i == 0) ? d : 24'(d[7:0]));
        @(posedge clk); #1;
        clear_pulses();
        model_accept(i, s, e, d);
        done = 1;
      end else begin
        chk("dout_valid_stall", i, o_valid[i], 0);
        @(posedge clk); #1;
        clear_pulses();
      end
      check_regs();
      @(negedge clk);
    end
    vld[i] = 0;
  endtask

  task automatic idle(input int n);
    vld = 0; dout_ready = 1;
    repeat (n) begin
      @(posedge clk); #1;
      clear_pulses();
      check_regs();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    vld = 0;
    rst = 1; #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send_pkt(input int i, input logic [3:0] ty, input int len);
    logic [23:0] d;
    d = 24'($urandom); d[3:0] = ty;
    beat(i, 1, len == 0, d);
    for (int b = 0; b < len; b++) beat(i, 0, b == len - 1, 24'($urandom));
  endtask

  // nb < 0 sends exactly the beats a legal packet needs
  task automatic send_ctrl(input int i, input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] il, input int nb);
    logic [3:0] nibs [9];
    logic [23:0] d;
    int s, n;
    s = sval(i);
    nibs = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], il};
    if (nb < 0) nb = (9 + s - 1) / s;
    d = 24'($urandom); d[3:0] = 4'hF;
    beat(i, 1, 0, d);
    for (int b = 0; b < nb; b++) begin
      d = 24'($urandom);
      for (int k = 0; k < s; k++) begin
        n = b * s + k;
        if (n < 9) d[k*8 +: 4] = nibs[n];
      end
      beat(i, 0, b == nb - 1, d);
    end
  endtask

  initial begin
    rst = 1; vld = 0; sp = 0; ep = 0; d0 = 0; d1 = 0; dout_ready = 1;
    model_reset();
    #1 check_regs();
    @(negedge clk); @(negedge clk);
    rst = 0;

    // 1920x1080 on S=3, exact beats
    beat(0, 1, 0, 24'h00000F);
    beat(0, 0, 0, 24'h080700);
    beat(0, 0, 0, 24'h040000);
    beat(0, 0, 1, 24'h000803);
    chk("w1920", 0, o_w[0], 16'd1920);
    chk("h1080", 0, o_h[0], 16'd1080);
    chk("il0", 0, o_il[0], 0);
    chk("no_err", 0, o_err[0], 0);
    idle(2);

    // truncated packet after defaults restored
    do_reset();
    send_ctrl(0, 16'd1234, 16'd567, 4'h0, 2);
    chk("trunc_err", 0, o_err[0], 1);
    chk("trunc_w", 0, o_w[0], 16'd640);
    idle(2);

    // video packet, and a sop+eop video beat
    send_pkt(0, 4'h0, 4);
    idle(1);
    send_pkt(0, 4'h0, 0);
    idle(1);

    // back-pressure during the 1920x1080 packet
    do_reset();
    bp = 1;
    beat(0, 1, 0, 24'h00000F);
    beat(0, 0, 0, 24'h080700);
    beat(0, 0, 0, 24'h040000);
    beat(0, 0, 1, 24'h000803);
    bp = 0;
    chk("bp_w1920", 0, o_w[0], 16'd1920);
    chk("bp_h1080", 0, o_h[0], 16'd1080);
    idle(2);

    // drop non-video on u1
    send_pkt(1, 4'h3, 3);
    send_pkt(1, 4'h0, 3);
    idle(1);

    // S=1: height 0 rejected, then abandoned packet followed by a legal one
    send_ctrl(1, 16'd320, 16'd0, 4'h0, -1);
    chk("h0_err", 1, o_err[1], 1);
    idle(1);
    beat(1, 1, 0, 24'h00000F);
    for (int b = 0; b < 4; b++) beat(1, 0, 0, 24'($urandom));
    send_ctrl(1, 16'd1280, 16'd720, 4'h1, -1);
    chk("s1_w1280", 1, o_w[1], 16'd1280);
    chk("s1_h720", 1, o_h[1], 16'd720);
    idle(1);

    // reset mid control packet, stray beats, then a legal packet
    beat(0, 1, 0, 24'h00000F);
    beat(0, 0, 0, 24'h123456);
    do_reset();
    beat(0, 0, 0, 24'h000111);
    beat(0, 0, 1, 24'h000222);
    send_ctrl(0, 16'd800, 16'd600, 4'h3, -1);
    chk("rst_w800", 0, o_w[0], 16'd800);
    idle(1);

    // randomized packet mix
    for (int r = 0; r < 40; r++) begin
      int i, sel;
      i = $urandom_range(0, 1);
      sel = $urandom_range(0, 4);
      bp = ($urandom_range(0, 3) == 0);
      case (sel)
        0: send_ctrl(i, 16'($urandom), 16'($urandom), 4'($urandom), -1);
        1: send_ctrl(i, 16'($urandom_range(0, 3)), 16'($urandom), 4'($urandom),
                     $urandom_range(1, 10));
        2: send_pkt(i, 4'h0, $urandom_range(0, 4));
        3: send_pkt(i, 4'($urandom_range(1, 14)), $urandom_range(0, 3));
        default: beat(i, 0, $urandom_range(0, 1), 24'($urandom));
      endcase
      bp = 0;
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
